// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instr_mem combinationally and holds the
// fetched word in an IF/ID register with valid/ready backpressure, redirect flush and HALT.
module fetch_unit #(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter int              PC_STEP  = 2,
   parameter logic [3:0]      HALT_OPC = 4'hF
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               resume,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   input  logic               if_ready,
   output logic               halted,
   output logic [15:0]        fetch_count
);

   typedef enum logic {RUN, HALT} state_t;

   state_t          state;
   logic [PC_W-1:0] pc;
   logic            fire;
   logic            is_halt;

   assign imem_addr = pc;
   assign fire      = (state == RUN) && !redirect_valid && (!if_valid || if_ready);
   assign is_halt   = (imem_data[INSTR_W-1 -: 4] == HALT_OPC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= '0;
         fetch_count <= '0;
         state       <= RUN;
         halted      <= 1'b0;
      end else if (redirect_valid) begin
         // flush: the word in IF/ID is dropped and nothing is fetched this cycle
         pc       <= {redirect_pc[PC_W-1:1], 1'b0};
         if_valid <= 1'b0;
         state    <= RUN;
         halted   <= 1'b0;
      end else begin
         if (fire) begin
            if_instr    <= imem_data;
            if_pc       <= pc;
            if_valid    <= 1'b1;
            pc          <= pc + PC_W'(PC_STEP);
            fetch_count <= fetch_count + 16'd1;
            if (is_halt) begin
               state  <= HALT;
               halted <= 1'b1;
            end
         end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
         end
         if (state == HALT && resume) begin
            state  <= RUN;
            halted <= 1'b0;
         end
      end
   end

endmodule
